nf10_axis_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that merges NUM_PORTS AXI-Stream slave inputs onto one AXI-Stream master output.
- Sits in front of the shell/user datapath and shares the single downstream stream interface between MAC/DMA sources.
- Grant is held from first beat to tlast, so packets never interleave. Output is registered as a one-deep pipeline slice.

---
 rtl/nf10_axis_arb_pkg.sv | 22 ++
 rtl/nf10_rr_pick.sv | 33 +++
 rtl/nf10_axis_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_nf10_axis_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_axis_arb_pkg.sv
// Shared definitions for the nf10 AXI-Stream round-robin arbiter: FSM states,
// width helper and the tuser source-stamp field position.
package nf10_axis_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } arb_state_t;

   localparam int SRC_STAMP_LSB = 24;
   localparam int SRC_STAMP_MSB = 31;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/nf10_rr_pick.sv
// Round-robin selector: first valid port searching upward from last_ptr+1,
// wrapping modulo NUM_PORTS. Purely combinational.
module nf10_rr_pick
   import nf10_axis_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4
)
(
   input  logic [NUM_PORTS-1:0] valid,
   input  logic [2:0]           last_ptr,
   output logic [2:0]           next_idx,
   output logic                 any_valid
);

   localparam int PW = clog2(NUM_PORTS);

   logic [PW-1:0] cand;

   // Walk farthest-to-nearest so the nearest valid candidate is the one left standing.
   always_comb begin
      next_idx  = last_ptr;
      any_valid = 1'b0;
      cand      = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         cand = PW'((int'(last_ptr) + k) % NUM_PORTS);
         if (valid[cand]) begin
            next_idx  = 3'(cand);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nf10_axis_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream inputs onto one
// registered output. Optional NF10_ARB_SRC_STAMP_EN stamps a one-hot source mask into tuser[31:24].
module nf10_axis_rr_arbiter
   import nf10_axis_arb_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_USER_WIDTH = 128,
   parameter int NUM_PORTS    = 4
)
(
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_PORTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic [NUM_PORTS*C_USER_WIDTH-1:0]   s_axis_tuser,
   input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                s_axis_tlast,
   output logic [NUM_PORTS-1:0]                s_axis_tready,
   output logic [C_DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0]           m_axis_tstrb,
   output logic [C_USER_WIDTH-1:0]             m_axis_tuser,
   output logic                                m_axis_tvalid,
   output logic                                m_axis_tlast,
   input  logic                                m_axis_tready,
   output logic [2:0]                          grant_port
);

   localparam int STRB_W = C_DATA_WIDTH / 8;
   localparam int PW     = clog2(NUM_PORTS);

   arb_state_t          state;
   arb_state_t          next_state;
   logic [2:0]          last_ptr;
   logic [2:0]          pick_idx;
   logic                pick_any;
   logic [PW-1:0]       gsel;
   logic                ready_cond;
   logic                beat_acc;
   logic [C_DATA_WIDTH-1:0] sel_data;
   logic [STRB_W-1:0]       sel_strb;
   logic [C_USER_WIDTH-1:0] sel_user;
   logic [C_USER_WIDTH-1:0] load_user;
   logic                    sel_last;
   logic                    sel_valid;

   assign gsel       = grant_port[PW-1:0];
   assign ready_cond = ~m_axis_tvalid | m_axis_tready;

   nf10_rr_pick #(
      .NUM_PORTS (NUM_PORTS)
   ) u_pick (
      .valid     (s_axis_tvalid),
      .last_ptr  (last_ptr),
      .next_idx  (pick_idx),
      .any_valid (pick_any)
   );

   always_comb begin
      sel_data  = '0;
      sel_strb  = '0;
      sel_user  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (PW'(i) == gsel) begin
            sel_data  = s_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            sel_strb  = s_axis_tstrb[i*STRB_W +: STRB_W];
            sel_user  = s_axis_tuser[i*C_USER_WIDTH +: C_USER_WIDTH];
            sel_last  = s_axis_tlast[i];
            sel_valid = s_axis_tvalid[i];
         end
      end
   end

`ifdef NF10_ARB_SRC_STAMP_EN
   logic [SRC_STAMP_MSB-SRC_STAMP_LSB:0] src_mask;

   always_comb begin
      src_mask             = '0;
      src_mask[grant_port] = 1'b1;
      load_user            = sel_user;
      load_user[SRC_STAMP_MSB:SRC_STAMP_LSB] = src_mask;
   end
`else
   assign load_user = sel_user;
`endif

   // Only the granted port ever sees ready; IDLE is a pure arbitration cycle.
   always_comb begin
      next_state    = state;
      s_axis_tready = '0;
      beat_acc      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               next_state = ST_PKT;
            end
         end
         ST_PKT: begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (PW'(i) == gsel) begin
                  s_axis_tready[i] = ready_cond;
               end
            end
            beat_acc = sel_valid & ready_cond;
            if (beat_acc && sel_last) begin
               next_state = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_port <= 3'(NUM_PORTS - 1);
         last_ptr   <= 3'(NUM_PORTS - 1);
      end else begin
         if (state == ST_IDLE && pick_any) begin
            grant_port <= pick_idx;
         end
         if (beat_acc && sel_last) begin
            last_ptr <= grant_port;
         end
      end
   end

   // One-deep output slice: a load wins over a drain so back-to-back beats stream.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else if (beat_acc) begin
         m_axis_tdata  <= sel_data;
         m_axis_tstrb  <= sel_strb;
         m_axis_tuser  <= load_user;
         m_axis_tlast  <= sel_last;
         m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nf10_axis_rr_arbiter.sv
// Directed self-checking bench for nf10_axis_rr_arbiter (4 ports, 32-bit data).
// Source data encodes {port, packet number, beat index} so order and origin are visible at the output.
module tb_nf10_axis_rr_arbiter;

   localparam int W = 32;
   localparam int U = 128;
   localparam int N = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N*W-1:0]    s_axis_tdata;
   logic [N*W/8-1:0]  s_axis_tstrb;
   logic [N*U-1:0]    s_axis_tuser;
   logic [N-1:0]      s_axis_tvalid;
   logic [N-1:0]      s_axis_tlast;
   logic [N-1:0]      s_axis_tready;
   logic [W-1:0]      m_axis_tdata;
   logic [W/8-1:0]    m_axis_tstrb;
   logic [U-1:0]      m_axis_tuser;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   logic [2:0]        grant_port;

   nf10_axis_rr_arbiter #(
      .C_DATA_WIDTH (W),
      .C_USER_WIDTH (U),
      .NUM_PORTS    (N)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .grant_port    (grant_port)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   data;
      logic [W/8-1:0] strb;
      logic [U-1:0]   user;
      logic           last;
      int             cyc;
   } beat_t;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int bp_mode = 0;

   int src_len   [N];
   int src_pkts  [N];
   int src_beat  [N];
   int src_pktno [N];
   logic [U-1:0] src_user [N];

   beat_t out_q[$];
   int    order_q[$];

   logic          prev_stall;
   logic [W+W/8+1:0] prev_ctl;
   logic [U-1:0]  prev_user;

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [W-1:0] expBeat(input int p, input int pkt, input int beat);
      return {8'(p), 8'(pkt), 16'(beat)};
   endfunction

   task automatic driveInputs();
      for (int p = 0; p < N; p++) begin
         s_axis_tvalid[p]             = (src_pkts[p] > 0);
         s_axis_tdata[p*W +: W]       = expBeat(p, src_pktno[p], src_beat[p]);
         s_axis_tstrb[p*(W/8) +: W/8] = 4'(p + 1);
         s_axis_tuser[p*U +: U]       = src_user[p];
         s_axis_tlast[p]              = (src_beat[p] == src_len[p] - 1);
      end
   endtask

   task automatic clearModel();
      for (int p = 0; p < N; p++) begin
         src_len[p]   = 1;
         src_pkts[p]  = 0;
         src_beat[p]  = 0;
         src_pktno[p] = 0;
         src_user[p]  = {32'(p), 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F};
      end
      out_q.delete();
      prev_stall = 1'b0;
   endtask

   task automatic resetDut();
      @(negedge clk);
      clearModel();
      driveInputs();
      m_axis_tready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // One cycle per iteration: drive at negedge, observe after settling, retire handshakes at posedge.
   task automatic applyStimulus(input int ncycles);
      logic [N-1:0] acc;
      for (int c = 0; c < ncycles; c++) begin
         @(negedge clk);
         driveInputs();
         m_axis_tready = (bp_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         checkOutput("ready_onehot0", 128'($onehot0(s_axis_tready)), 128'd1);
         if (prev_stall) begin
            checkOutput("stable_ctl", 128'({m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata}), 128'(prev_ctl));
            checkOutput("stable_user", m_axis_tuser, prev_user);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_ctl   = {m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata};
         prev_user  = m_axis_tuser;
         if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back('{data: m_axis_tdata, strb: m_axis_tstrb, user: m_axis_tuser,
                              last: m_axis_tlast, cyc: cycle});
         end
         acc = s_axis_tvalid & s_axis_tready;
         @(posedge clk);
         cycle++;
         for (int p = 0; p < N; p++) begin
            if (acc[p]) begin
               if (src_beat[p] == src_len[p] - 1) begin
                  src_beat[p] = 0;
                  src_pkts[p]--;
                  src_pktno[p]++;
               end else begin
                  src_beat[p]++;
               end
            end
         end
      end
   endtask

   task automatic buildOrder();
      order_q.delete();
      for (int i = 0; i < out_q.size(); i++) begin
         if (i == 0 || out_q[i-1].last) begin
            order_q.push_back(int'(out_q[i].data[31:24]));
         end
      end
   endtask

   initial begin
      int c0;
      int guard;
      int exp_order [7];
      logic [U-1:0] exp_user;

      reset = 1'b0;
      m_axis_tready = 1'b1;
      clearModel();
      driveInputs();

      // Reset state
      resetDut();
      checkOutput("rst_m_tvalid", 128'(m_axis_tvalid), 128'd0);
      checkOutput("rst_m_tlast", 128'(m_axis_tlast), 128'd0);
      checkOutput("rst_m_tdata", 128'(m_axis_tdata), 128'd0);
      checkOutput("rst_m_tuser", m_axis_tuser, 128'd0);
      checkOutput("rst_s_tready", 128'(s_axis_tready), 128'd0);
      checkOutput("rst_grant", 128'(grant_port), 128'd3);

      // Single port, 16 beats, full throughput
      $display("[TB] single port 16-beat packet");
      src_len[0] = 16;
      src_pkts[0] = 1;
      c0 = cycle;
      applyStimulus(30);
      checkOutput("sp_count", 128'(out_q.size()), 128'd16);
      if (out_q.size() == 16) begin
         checkOutput("sp_latency", 128'(out_q[0].cyc - c0), 128'd2);
         checkOutput("sp_no_gaps", 128'(out_q[15].cyc - out_q[0].cyc), 128'd15);
         for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("sp_data%0d", i), 128'(out_q[i].data), 128'(expBeat(0, 0, i)));
            checkOutput($sformatf("sp_last%0d", i), 128'(out_q[i].last), 128'(i == 15));
         end
      end

      // Round robin: 0,2,0,2 then 1,2,3 after a port-2 grant -> 3,1,2
      $display("[TB] round-robin order");
      resetDut();
      src_len[0] = 3; src_pkts[0] = 2;
      src_len[2] = 3; src_pkts[2] = 2;
      applyStimulus(30);
      src_len[1] = 3; src_pkts[1] = 1;
      src_pkts[2] = 1;
      src_len[3] = 3; src_pkts[3] = 1;
      applyStimulus(40);
      exp_order = '{0, 2, 0, 2, 3, 1, 2};
      buildOrder();
      checkOutput("rr_pkt_count", 128'(order_q.size()), 128'd7);
      if (order_q.size() == 7) begin
         for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("rr_src%0d", i), 128'(order_q[i]), 128'(exp_order[i]));
         end
      end

      // No interleave: port 1 requests during beat 2 of port 0's 8-beat packet
      $display("[TB] no interleave");
      resetDut();
      src_len[0] = 8; src_pkts[0] = 1;
      guard = 0;
      while (src_beat[0] != 2 && guard < 20) begin
         applyStimulus(1);
         guard++;
      end
      checkOutput("ni_reach_beat2", 128'(guard < 20), 128'd1);
      src_len[1] = 4; src_pkts[1] = 1;
      applyStimulus(40);
      checkOutput("ni_count", 128'(out_q.size()), 128'd12);
      if (out_q.size() == 12) begin
         for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("ni_data%0d", i), 128'(out_q[i].data),
                        128'((i < 8) ? expBeat(0, 0, i) : expBeat(1, 0, i - 8)));
         end
         checkOutput("ni_contiguous", 128'(out_q[7].cyc - out_q[0].cyc), 128'd7);
         checkOutput("ni_idle_gap", 128'(out_q[8].cyc - out_q[7].cyc), 128'd2);
      end

      // Random backpressure on a 14-beat packet from port 3
      $display("[TB] backpressure");
      resetDut();
      bp_mode = 1;
      src_len[3] = 14; src_pkts[3] = 1;
      applyStimulus(200);
      bp_mode = 0;
      checkOutput("bp_count", 128'(out_q.size()), 128'd14);
      if (out_q.size() == 14) begin
         for (int i = 0; i < 14; i++) begin
            checkOutput($sformatf("bp_data%0d", i), 128'(out_q[i].data), 128'(expBeat(3, 0, i)));
            checkOutput($sformatf("bp_strb%0d", i), 128'(out_q[i].strb), 128'd4);
            checkOutput($sformatf("bp_last%0d", i), 128'(out_q[i].last), 128'(i == 13));
         end
      end

      // Reset asserted while beat 5 of a 10-beat packet is offered
      $display("[TB] reset mid-packet");
      resetDut();
      src_len[1] = 10; src_pkts[1] = 1;
      guard = 0;
      while (src_beat[1] != 5 && guard < 20) begin
         applyStimulus(1);
         guard++;
      end
      checkOutput("rm_reach_beat5", 128'(guard < 20), 128'd1);
      @(negedge clk);
      src_pkts[1] = 0;
      src_beat[1] = 0;
      driveInputs();
      m_axis_tready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rm_m_tvalid", 128'(m_axis_tvalid), 128'd0);
      checkOutput("rm_s_tready", 128'(s_axis_tready), 128'd0);
      checkOutput("rm_grant", 128'(grant_port), 128'd3);
      out_q.delete();
      prev_stall = 1'b0;
      src_len[0] = 2; src_pkts[0] = 1;
      src_len[1] = 2; src_pkts[1] = 1;
      applyStimulus(20);
      buildOrder();
      checkOutput("rm_pkt_count", 128'(order_q.size()), 128'd2);
      if (order_q.size() == 2) begin
         checkOutput("rm_first_src", 128'(order_q[0]), 128'd0);
         checkOutput("rm_second_src", 128'(order_q[1]), 128'd1);
      end

      // tuser pass-through / source stamp on port 2
      $display("[TB] tuser source stamp");
      resetDut();
      src_user[2] = 128'hCAFEBEEFDEADCAFE;
      src_len[2] = 2; src_pkts[2] = 1;
      applyStimulus(20);
      exp_user = 128'hCAFEBEEFDEADCAFE;
`ifdef NF10_ARB_SRC_STAMP_EN
      exp_user[31:24] = 8'h04;
`endif
      checkOutput("st_count", 128'(out_q.size()), 128'd2);
      if (out_q.size() == 2) begin
         for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("st_user%0d", i), out_q[i].user, exp_user);
            checkOutput($sformatf("st_strb%0d", i), 128'(out_q[i].strb), 128'd3);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

endmodule
